// File: rtl/pir_display_ctrl.sv
// Purpose : presence-driven display sequencer; syncs/debounces the PIR input and fades the picture in/out frame-locked.
// Latency : PIR edge -> led after SYNC_STAGES+DEBOUNCE_CYCLES clocks; led -> state/outputs one clock later.
// Backpressure: none; frame_start is a free-running strobe and every output is a register sampled by vga_sync.
//
// Ports:
//   clk_148Mhz  - pixel clock, all logic on its rising edge
//   reset       - asynchronous active-low reset
//   pir_signal  - raw PIR sensor level, asynchronous to clk_148Mhz
//   frame_start - one-cycle pulse at the first blanking line of each frame
//   display_en  - 1 = picture may be shown, 0 = force black
//   fade_level  - brightness scale 0 (black) .. 15 (full)
//   led         - debounced presence indicator
//   state_dbg   - current state encoding (0 IDLE, 1 FADE_IN, 2 ACTIVE, 3 HOLD, 4 FADE_OUT)
module pir_display_ctrl #(
  parameter int SYNC_STAGES      = 2,
  parameter int DEBOUNCE_CYCLES  = 1_480_000,
  parameter int HOLD_FRAMES      = 300,
  parameter int FADE_STEP_FRAMES = 4
) (
  input  logic       clk_148Mhz,
  input  logic       reset,
  input  logic       pir_signal,
  input  logic       frame_start,
  output logic       display_en,
  output logic [3:0] fade_level,
  output logic       led,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FADE_IN  = 3'd1;
  localparam logic [2:0] ST_ACTIVE   = 3'd2;
  localparam logic [2:0] ST_HOLD     = 3'd3;
  localparam logic [2:0] ST_FADE_OUT = 3'd4;

  // Counter widths are kept at least one bit so the degenerate parameter
  // values (1 cycle / 1 frame) still elaborate.
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HD_W = $clog2(HOLD_FRAMES + 1);
  localparam int SP_W = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HD_W-1:0] HOLD_LAST = HD_W'(HOLD_FRAMES - 1);
  localparam logic [SP_W-1:0] STEP_LAST = SP_W'(FADE_STEP_FRAMES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pir_sync;
  logic                   pir_stable;
  logic [DB_W-1:0]        db_cnt;
  logic                   motion;

  logic [2:0]             state;
  logic [SP_W-1:0]        step_cnt;
  logic [HD_W-1:0]        hold_cnt;
  logic                   tick;

  // ---------------------------------------------------------------------------
  // Synchroniser: pir_signal shifts in at bit 0, pir_sync is the oldest stage.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_148Mhz or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pir_signal};
    end
  end

  assign pir_sync = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce: a new level must be seen on DEBOUNCE_CYCLES consecutive clocks.
  // Any return to the stable level restarts the count, so short pulses vanish.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_148Mhz or negedge reset) begin
    if (!reset) begin
      db_cnt     <= '0;
      pir_stable <= 1'b0;
    end else if (pir_sync == pir_stable) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      pir_stable <= pir_sync;
      db_cnt     <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign led    = pir_stable;
  assign motion = pir_stable;

  // A fade step happens on every FADE_STEP_FRAMES-th frame_start seen in a fade state.
  assign tick = frame_start && (step_cnt == STEP_LAST);

  // ---------------------------------------------------------------------------
  // Frame-locked sequencer. Motion is always checked before frame_start so a
  // change of presence wins over a coincident tick or hold expiry.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_148Mhz or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      fade_level <= 4'd0;
      display_en <= 1'b0;
      step_cnt   <= '0;
      hold_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          fade_level <= 4'd0;
          display_en <= 1'b0;
          step_cnt   <= '0;
          hold_cnt   <= '0;
          if (motion) begin
            state      <= ST_FADE_IN;
            display_en <= 1'b1;
          end
        end

        ST_FADE_IN: begin
          display_en <= 1'b1;
          if (!motion) begin
            state    <= ST_FADE_OUT;
            step_cnt <= '0;
          end else if (frame_start) begin
            if (tick) begin
              step_cnt <= '0;
              // Saturate at 15; reaching full brightness ends the fade.
              if (fade_level >= 4'd14) begin
                fade_level <= 4'd15;
                state      <= ST_ACTIVE;
              end else begin
                fade_level <= fade_level + 4'd1;
              end
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end

        ST_ACTIVE: begin
          fade_level <= 4'd15;
          display_en <= 1'b1;
          step_cnt   <= '0;
          if (!motion) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
          end
        end

        ST_HOLD: begin
          display_en <= 1'b1;
          if (motion) begin
            state    <= ST_ACTIVE;
            hold_cnt <= '0;
          end else if (frame_start) begin
            if (hold_cnt == HOLD_LAST) begin
              state    <= ST_FADE_OUT;
              hold_cnt <= '0;
              step_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end

        ST_FADE_OUT: begin
          display_en <= 1'b1;
          if (motion) begin
            // Resume fading in from wherever the level currently is.
            state    <= ST_FADE_IN;
            step_cnt <= '0;
          end else if (frame_start) begin
            if (tick) begin
              step_cnt <= '0;
              // Saturate at 0; the step that lands on black also blanks the output.
              if (fade_level <= 4'd1) begin
                fade_level <= 4'd0;
                state      <= ST_IDLE;
                display_en <= 1'b0;
              end else begin
                fade_level <= fade_level - 4'd1;
              end
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end

        default: begin
          // Unused encodings fall back to a blank IDLE.
          state      <= ST_IDLE;
          fade_level <= 4'd0;
          display_en <= 1'b0;
          step_cnt   <= '0;
          hold_cnt   <= '0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pir_display_ctrl.sv
// Purpose : directed table-driven bench for pir_display_ctrl with small debounce/hold/step parameters.
// Latency : frame_start pulses every 20 clocks; outputs sampled 1 time unit after each rising edge.
// Backpressure: none; the bench drives free-running inputs only.
module tb_pir_display_ctrl;

  localparam int SYNC_STAGES      = 2;
  localparam int DEBOUNCE_CYCLES  = 4;
  localparam int HOLD_FRAMES      = 3;
  localparam int FADE_STEP_FRAMES = 2;
  localparam int FRAME_PERIOD     = 20;

  logic       clk_148Mhz = 1'b0;
  logic       reset;
  logic       pir_signal;
  logic       frame_start;
  logic       display_en;
  logic [3:0] fade_level;
  logic       led;
  logic [2:0] state_dbg;

  int n_vec = 0;
  int n_err = 0;
  int phase = 0;

  typedef struct {
    logic       pir;
    int         cycles;
    int         frames;
    logic       en;
    logic [3:0] fade;
    logic       led;
    logic [2:0] st;
  } vec_t;

  vec_t tbl[$];

  pir_display_ctrl #(
    .SYNC_STAGES      (SYNC_STAGES),
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .HOLD_FRAMES      (HOLD_FRAMES),
    .FADE_STEP_FRAMES (FADE_STEP_FRAMES)
  ) dut (
    .clk_148Mhz  (clk_148Mhz),
    .reset       (reset),
    .pir_signal  (pir_signal),
    .frame_start (frame_start),
    .display_en  (display_en),
    .fade_level  (fade_level),
    .led         (led),
    .state_dbg   (state_dbg)
  );

  always #5 clk_148Mhz = ~clk_148Mhz;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got %0d vectors, want run to finish", n_vec);
    $fatal(1);
  end

  // One clock; frame_start is high on every FRAME_PERIOD-th edge.
  task automatic step();
    frame_start = (phase == FRAME_PERIOD - 1);
    @(posedge clk_148Mhz);
    #1;
    phase = frame_start ? 0 : phase + 1;
    frame_start = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until n frame_start pulses have been sampled by the DUT.
  task automatic run_frames(input int n);
    int got;
    got = 0;
    while (got < n) begin
      step();
      if (phase == 0) got++;
    end
  endtask

  task automatic check(input string name, input logic en, input logic [3:0] fd,
                       input logic ld, input logic [2:0] st);
    n_vec++;
    if (display_en !== en || fade_level !== fd || led !== ld || state_dbg !== st) begin
      n_err++;
      $display("FAIL %s: got en=%0b fade=%0d led=%0b state=%0d, want en=%0b fade=%0d led=%0b state=%0d",
               name, display_en, fade_level, led, state_dbg, en, fd, ld, st);
    end
  endtask

  task automatic add(input logic pir, input int cyc, input int frm, input logic en,
                     input logic [3:0] fd, input logic ld, input logic [2:0] st);
    vec_t v;
    v.pir = pir; v.cycles = cyc; v.frames = frm;
    v.en = en; v.fade = fd; v.led = ld; v.st = st;
    tbl.push_back(v);
  endtask

  task automatic apply_row(input int i);
    pir_signal = tbl[i].pir;
    steps(tbl[i].cycles);
    run_frames(tbl[i].frames);
    check($sformatf("row%0d", i), tbl[i].en, tbl[i].fade, tbl[i].led, tbl[i].st);
  endtask

  initial begin
    //   pir cyc frm  en fade led st
    add(1, 0,  1,  1,  0, 1, 1);  // 0  first frame in FADE_IN: no step yet
    add(1, 0,  1,  1,  1, 1, 1);  // 1  second frame: +1
    add(1, 0, 10,  1,  6, 1, 1);  // 2  12 frames -> 6
    add(1, 0, 17,  1, 14, 1, 1);  // 3  29 frames -> 14
    add(1, 0,  1,  1, 15, 1, 2);  // 4  30th frame -> 15, ACTIVE
    add(1, 0,  2,  1, 15, 1, 2);  // 5  frames ignored in ACTIVE
    add(0, 5,  0,  1, 15, 1, 2);  // 6  led not yet fallen
    add(0, 1,  0,  1, 15, 0, 2);  // 7  led falls 6 clocks after edge
    add(0, 1,  0,  1, 15, 0, 3);  // 8  HOLD next clock
    add(0, 0,  2,  1, 15, 0, 3);  // 9  two hold frames
    add(0, 0,  1,  1, 15, 0, 4);  // 10 third hold frame -> FADE_OUT
    add(0, 0,  1,  1, 15, 0, 4);  // 11 no step yet
    add(0, 0,  1,  1, 14, 0, 4);  // 12 first decrement
    add(0, 0, 27,  1,  1, 0, 4);  // 13 29 fade-out frames -> 1
    add(0, 0,  1,  0,  0, 0, 0);  // 14 30th -> 0, IDLE, blanked
    add(0, 0,  2,  0,  0, 0, 0);  // 15 frames ignored in IDLE
    add(1, 7,  0,  1,  0, 1, 1);  // 16 second presence
    add(1, 0, 30,  1, 15, 1, 2);  // 17 full fade-in again
    add(0, 7,  0,  1, 15, 0, 3);  // 18 HOLD
    add(0, 0,  2,  1, 15, 0, 3);  // 19 two hold frames
    add(1, 7,  0,  1, 15, 1, 2);  // 20 motion back -> ACTIVE at 15
    add(0, 7,  0,  1, 15, 0, 3);  // 21 HOLD restarts
    add(0, 0,  2,  1, 15, 0, 3);  // 22 two frames not enough
    add(0, 0,  1,  1, 15, 0, 4);  // 23 third frame -> FADE_OUT
    add(0, 0, 12,  1,  9, 0, 4);  // 24 six decrements -> 9
    add(0, 7,  0,  1, 10, 0, 4);  // 25 after coincident-tick sequence: back to FADE_OUT
    add(0, 0, 19,  1,  1, 0, 4);  // 26 nine decrements -> 1
    add(0, 0,  1,  0,  0, 0, 0);  // 27 -> 0, IDLE

    reset       = 1'b0;
    pir_signal  = 1'b0;
    frame_start = 1'b0;
    steps(2);
    check("reset_init", 1'b0, 4'd0, 1'b0, 3'd0);
    reset = 1'b1;
    steps(3);
    check("post_release", 1'b0, 4'd0, 1'b0, 3'd0);

    // Three-clock pulse must be swallowed by the debouncer.
    pir_signal = 1'b1;
    steps(3);
    pir_signal = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      check($sformatf("glitch%0d", i), 1'b0, 4'd0, 1'b0, 3'd0);
    end

    // led exactly 6 clocks after the edge, FADE_IN one clock later.
    pir_signal = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      check($sformatf("rise%0d", i), (i >= 7), 4'd0, (i >= 6), (i >= 7) ? 3'd1 : 3'd0);
    end

    for (int i = 0; i <= 24; i++) apply_row(i);

    // Fade-out at 9 just after a decrement (phase 0): frame 20 clocks on is a
    // non-tick, frame 40 clocks on is a tick. Raise PIR so led rises at clock 39.
    steps(33);
    pir_signal = 1'b1;
    steps(5);
    check("coin_pre_led", 1'b1, 4'd9, 1'b0, 3'd4);
    step();
    check("coin_led", 1'b1, 4'd9, 1'b1, 3'd4);
    step();
    check("coin_tick", 1'b1, 4'd9, 1'b1, 3'd1);
    run_frames(1);
    check("coin_after1", 1'b1, 4'd9, 1'b1, 3'd1);
    run_frames(1);
    check("coin_after2", 1'b1, 4'd10, 1'b1, 3'd1);

    for (int i = 25; i <= 27; i++) apply_row(i);

    // Asynchronous reset mid-run with PIR high.
    pir_signal = 1'b1;
    steps(10);
    check("pre_reset", 1'b1, 4'd0, 1'b1, 3'd1);
    #3;
    reset = 1'b0;
    #1;
    check("reset_async", 1'b0, 4'd0, 1'b0, 3'd0);
    pir_signal = 1'b0;
    steps(2);
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      check($sformatf("post_reset%0d", i), 1'b0, 4'd0, 1'b0, 3'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
